// File: rtl/sht40_measure_sequencer.sv
// SHT40 measurement controller. It drives the I2C byte master through the command write,
// the conversion wait and the 6-byte read, checks both CRCs, retries, and publishes raw words.
module sht40_measure_sequencer #(
    parameter logic [6:0] I2C_ADDR      = 7'h44,
    parameter logic [7:0] MEAS_CMD      = 8'hFD,
    parameter int         WAIT_CYCLES   = 1000000,
    parameter int         PERIOD_CYCLES = 100000000,
    parameter int         RETRY_GAP     = 1000,
    parameter int         MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        auto_en,
    output logic        i2c_req,
    output logic        i2c_rw,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_wdata,
    output logic [2:0]  i2c_nbytes,
    input  logic        i2c_ack,
    input  logic        i2c_rx_valid,
    input  logic [7:0]  i2c_rx_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic [15:0] temp_raw,
    output logic [15:0] rh_raw,
    output logic        result_valid,
    output logic        busy,
    output logic        error,
    output logic [1:0]  error_code
);

    typedef enum logic [3:0] {
        IDLE, WR_REQ, WR_WAIT, MEAS_WAIT, RD_REQ, RD_WAIT, CHECK, FAIL_CHK, RETRY_WAIT
    } state_t;

    localparam logic [31:0] WAIT_LAST   = 32'(WAIT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST    = 32'(RETRY_GAP - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);

    state_t      state, next_state;
    logic [31:0] wait_cnt;
    logic [31:0] period_cnt;
    logic [7:0]  attempts;
    logic [2:0]  byte_cnt;
    logic [7:0]  temp_hi, temp_lo, rh_hi, rh_lo;
    logic [7:0]  crc_run;
    logic        crc_bad;
    logic        rd_nack;
    logic [1:0]  fail_code;
    logic        go;
    logic        check_fail;
    logic [1:0]  check_code;

    // One byte of CRC-8 (poly 0x31, MSB first), unrolled so each received byte folds in one cycle.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        end
        return c;
    endfunction

    assign go        = start || (auto_en && period_cnt == '0);
    assign i2c_addr  = I2C_ADDR;
    assign i2c_wdata = MEAS_CMD;

    always_comb begin
        check_fail = rd_nack || (byte_cnt < 3'd6) || crc_bad;
        if (rd_nack)
            check_code = 2'd1;
        else if (byte_cnt < 3'd6)
            check_code = 2'd3;
        else
            check_code = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (go) next_state = WR_REQ;
            WR_REQ:     if (i2c_ack) next_state = WR_WAIT;
            WR_WAIT:    if (i2c_done) next_state = i2c_nack ? FAIL_CHK : MEAS_WAIT;
            MEAS_WAIT:  if (wait_cnt == WAIT_LAST) next_state = RD_REQ;
            RD_REQ:     if (i2c_ack) next_state = RD_WAIT;
            RD_WAIT:    if (i2c_done) next_state = CHECK;
            CHECK:      next_state = check_fail ? FAIL_CHK : IDLE;
            FAIL_CHK:   next_state = (attempts < RETRY_LIMIT) ? RETRY_WAIT : IDLE;
            RETRY_WAIT: if (wait_cnt == GAP_LAST) next_state = WR_REQ;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        i2c_req    = 1'b0;
        i2c_rw     = 1'b0;
        i2c_nbytes = 3'd0;
        case (state)
            WR_REQ: i2c_req = 1'b1;
            RD_REQ: begin
                i2c_req    = 1'b1;
                i2c_rw     = 1'b1;
                i2c_nbytes = 3'd6;
            end
            default: ;
        endcase
        busy = (state != IDLE);
    end

    // Shared by the conversion wait and the retry gap; the two never overlap.
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == MEAS_WAIT || state == RETRY_WAIT)
            wait_cnt <= wait_cnt + 32'd1;
        else
            wait_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            period_cnt <= '0;
        else if (!auto_en || (state == IDLE && go))
            period_cnt <= PERIOD_LAST;
        else if (period_cnt != '0)
            period_cnt <= period_cnt - 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            attempts     <= '0;
            byte_cnt     <= '0;
            temp_hi      <= '0;
            temp_lo      <= '0;
            rh_hi        <= '0;
            rh_lo        <= '0;
            crc_run      <= '0;
            crc_bad      <= 1'b0;
            rd_nack      <= 1'b0;
            fail_code    <= '0;
            temp_raw     <= '0;
            rh_raw       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            error_code   <= '0;
        end else begin
            result_valid <= 1'b0;
            error        <= 1'b0;
            case (state)
                IDLE: if (go) attempts <= '0;
                WR_WAIT: if (i2c_done && i2c_nack) fail_code <= 2'd1;
                RD_REQ: begin
                    byte_cnt <= '0;
                    crc_bad  <= 1'b0;
                    rd_nack  <= 1'b0;
                end
                RD_WAIT: begin
                    // The running CRC restarts at the first byte of each word.
                    if (i2c_rx_valid && byte_cnt < 3'd6) begin
                        byte_cnt <= byte_cnt + 3'd1;
                        case (byte_cnt)
                            3'd0: begin
                                temp_hi <= i2c_rx_data;
                                crc_run <= crc8_byte(8'hFF, i2c_rx_data);
                            end
                            3'd1: begin
                                temp_lo <= i2c_rx_data;
                                crc_run <= crc8_byte(crc_run, i2c_rx_data);
                            end
                            3'd3: begin
                                rh_hi   <= i2c_rx_data;
                                crc_run <= crc8_byte(8'hFF, i2c_rx_data);
                            end
                            3'd4: begin
                                rh_lo   <= i2c_rx_data;
                                crc_run <= crc8_byte(crc_run, i2c_rx_data);
                            end
                            default: if (i2c_rx_data != crc_run) crc_bad <= 1'b1;
                        endcase
                    end
                    if (i2c_done) rd_nack <= i2c_nack;
                end
                CHECK: begin
                    if (check_fail) begin
                        fail_code <= check_code;
                    end else begin
                        temp_raw     <= {temp_hi, temp_lo};
                        rh_raw       <= {rh_hi, rh_lo};
                        result_valid <= 1'b1;
                    end
                end
                FAIL_CHK: begin
                    if (attempts < RETRY_LIMIT) begin
                        attempts <= attempts + 8'd1;
                    end else begin
                        error      <= 1'b1;
                        error_code <= fail_code;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sht40_measure_sequencer.sv
// Randomized bench for the SHT40 sequencer: a responder plays the I2C master and a
// per-measurement outcome model predicts results, error codes and request counts.
module tb_sht40_measure_sequencer;

    localparam int WAIT_CYCLES   = 100;
    localparam int PERIOD_CYCLES = 5000;
    localparam int RETRY_GAP     = 50;
    localparam int MAX_RETRY     = 3;

    typedef enum logic [2:0] {K_GOOD, K_EXTRA, K_WNACK, K_RNACK, K_SHORT, K_BADCRC} kind_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        auto_en;
    logic        i2c_req;
    logic        i2c_rw;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_wdata;
    logic [2:0]  i2c_nbytes;
    logic        i2c_ack;
    logic        i2c_rx_valid;
    logic [7:0]  i2c_rx_data;
    logic        i2c_done;
    logic        i2c_nack;
    logic [15:0] temp_raw;
    logic [15:0] rh_raw;
    logic        result_valid;
    logic        busy;
    logic        error;
    logic [1:0]  error_code;

    sht40_measure_sequencer #(
        .I2C_ADDR(7'h44), .MEAS_CMD(8'hFD), .WAIT_CYCLES(WAIT_CYCLES),
        .PERIOD_CYCLES(PERIOD_CYCLES), .RETRY_GAP(RETRY_GAP), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
        .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_nbytes(i2c_nbytes), .i2c_ack(i2c_ack), .i2c_rx_valid(i2c_rx_valid),
        .i2c_rx_data(i2c_rx_data), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .temp_raw(temp_raw), .rh_raw(rh_raw), .result_valid(result_valid),
        .busy(busy), .error(error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rv_count = 0;
    int err_count = 0;
    int wr_count = 0;
    int last_rv_cyc = 0;
    int wr_rise[$];
    logic req_prev = 1'b0;

    logic [15:0] m_temp;
    logic [15:0] m_rh;
    logic [1:0]  m_code;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and request-edge bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (result_valid) begin
            rv_count++;
            last_rv_cyc = cyc;
        end
        if (error) err_count++;
        if (i2c_req && !req_prev && !i2c_rw) begin
            wr_count++;
            wr_rise.push_back(cyc);
        end
        req_prev = i2c_req;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // CRC-8 as the remainder of polynomial long division by x^8+x^5+x^4+1, init folded into the top byte.
    function automatic logic [7:0] refCrc(input logic [15:0] w);
        logic [23:0] rem;
        rem = {w ^ 16'hFF00, 8'h00};
        for (int i = 23; i >= 8; i--) begin
            if (rem[i]) rem = rem ^ (24'h131 << (i - 8));
        end
        return rem[7:0];
    endfunction

    function automatic logic [1:0] codeOf(input kind_t k);
        case (k)
            K_WNACK, K_RNACK: return 2'd1;
            K_SHORT:          return 2'd3;
            K_BADCRC:         return 2'd2;
            default:          return 2'd0;
        endcase
    endfunction

    function automatic kind_t randKind();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 3) return K_GOOD;
        if (r == 4) return K_EXTRA;
        if (r == 5) return K_WNACK;
        if (r == 6) return K_RNACK;
        if (r == 7) return K_SHORT;
        return K_BADCRC;
    endfunction

    task automatic resetCheck();
        checkOutput("rst_req", i2c_req, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rw", i2c_rw, 1'b0);
        checkOutput("rst_nbytes", i2c_nbytes, 3'd0);
        checkOutput("rst_addr", i2c_addr, 7'h44);
        checkOutput("rst_wdata", i2c_wdata, 8'hFD);
        checkOutput("rst_temp", temp_raw, 16'h0);
        checkOutput("rst_rh", rh_raw, 16'h0);
        checkOutput("rst_valid", result_valid, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_code", error_code, 2'd0);
        m_temp = '0;
        m_rh   = '0;
        m_code = '0;
    endtask

    task automatic waitReq(input logic rwExp, input int budget, input string tag, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (i2c_req) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(tag, ok, 1'b1);
        if (ok) checkOutput("req_rw", i2c_rw, rwExp);
    endtask

    task automatic holdAndAck(input logic rwExp);
        int hold;
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("req_hold", {i2c_req, i2c_rw}, {1'b1, rwExp});
        end
        i2c_ack = 1'b1;
        @(negedge clk);
        i2c_ack = 1'b0;
        checkOutput("req_drop", i2c_req, 1'b0);
    endtask

    task automatic pulseDone(input logic nack, output int doneCyc);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        i2c_done = 1'b1;
        i2c_nack = nack;
        doneCyc  = cyc;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
    endtask

    // Serves one attempt as the I2C master, shaping the read according to the attempt kind.
    task automatic applyStimulus(input kind_t kind, input logic [15:0] t, input logic [15:0] r,
                                 input int idx, input int prevEnd, input bit midStart,
                                 output int endCyc, output bit ok);
        logic [7:0] b [7];
        int nsend;
        bit tail;
        bit doneSent;
        endCyc = cyc;
        waitReq(1'b0, PERIOD_CYCLES + 200, "wr_req_seen", ok);
        if (!ok) return;
        if (idx > 0) checkOutput("retry_gap", (cyc - prevEnd) >= RETRY_GAP, 1'b1);
        checkOutput("wr_addr", i2c_addr, 7'h44);
        checkOutput("wr_wdata", i2c_wdata, 8'hFD);
        checkOutput("wr_nbytes", i2c_nbytes, 3'd0);
        holdAndAck(1'b0);
        pulseDone(kind == K_WNACK, endCyc);
        if (kind == K_WNACK) return;
        if (midStart) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waitReq(1'b1, WAIT_CYCLES + 50, "rd_req_seen", ok);
        if (!ok) return;
        checkOutput("meas_wait", (cyc - endCyc) >= WAIT_CYCLES, 1'b1);
        checkOutput("rd_nbytes", i2c_nbytes, 3'd6);
        holdAndAck(1'b1);
        b[0] = t[15:8];
        b[1] = t[7:0];
        b[2] = refCrc(t);
        b[3] = r[15:8];
        b[4] = r[7:0];
        b[5] = refCrc(r);
        b[6] = 8'($urandom);
        case (kind)
            K_EXTRA: nsend = 7;
            K_SHORT: nsend = $urandom_range(0, 5);
            K_RNACK: nsend = $urandom_range(0, 6);
            K_BADCRC: begin
                nsend = 6;
                b[$urandom_range(0, 5)] ^= 8'(8'h01 << $urandom_range(0, 7));
            end
            default: nsend = 6;
        endcase
        tail = ($urandom_range(0, 1) == 1) && (nsend > 0);
        doneSent = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            i2c_rx_valid = 1'b1;
            i2c_rx_data  = b[i];
            if (tail && i == nsend - 1) begin
                i2c_done = 1'b1;
                i2c_nack = (kind == K_RNACK);
                endCyc   = cyc;
                doneSent = 1'b1;
            end
            @(negedge clk);
            i2c_rx_valid = 1'b0;
            i2c_done     = 1'b0;
            i2c_nack     = 1'b0;
        end
        if (!doneSent) pulseDone(kind == K_RNACK, endCyc);
    endtask

    // Outcome model: the first clean frame wins; otherwise the last of MAX_RETRY+1 failures is reported.
    task automatic runMeasurement(input kind_t ks[4], input logic [15:0] t, input logic [15:0] r,
                                  input bit doStart, input bit midStart);
        int n;
        bit success;
        int rv0, er0, wr0;
        int endCyc, prevEnd, k;
        bit ok;
        n = MAX_RETRY + 1;
        success = 1'b0;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            if (ks[i] == K_GOOD || ks[i] == K_EXTRA) begin
                n = i + 1;
                success = 1'b1;
                break;
            end
        end
        rv0 = rv_count;
        er0 = err_count;
        wr0 = wr_count;
        if (doStart) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        prevEnd = cyc;
        endCyc  = cyc;
        ok = 1'b1;
        for (int i = 0; i < n && ok; i++) begin
            applyStimulus(ks[i], t, r, i, prevEnd, midStart && i == 0, endCyc, ok);
            prevEnd = endCyc;
        end
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checkOutput("idle_after", busy, 1'b0);
        if (success) begin
            m_temp = t;
            m_rh   = r;
        end else begin
            m_code = codeOf(ks[MAX_RETRY]);
        end
        checkOutput("result_pulses", rv_count - rv0, success);
        checkOutput("error_pulses", err_count - er0, !success);
        checkOutput("wr_requests", wr_count - wr0, n);
        checkOutput("temp_raw", temp_raw, m_temp);
        checkOutput("rh_raw", rh_raw, m_rh);
        checkOutput("error_code", error_code, m_code);
        if (success) checkOutput("result_latency", last_rv_cyc - endCyc, 2);
    endtask

    initial begin
        kind_t ks[4];
        kind_t allGood[4];
        int s0, target, dc;
        bit ok;

        rst = 1'b1;
        start = 1'b0;
        auto_en = 1'b0;
        i2c_ack = 1'b0;
        i2c_rx_valid = 1'b0;
        i2c_rx_data = 8'h00;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        allGood = '{K_GOOD, K_GOOD, K_GOOD, K_GOOD};
        repeat (3) @(negedge clk);
        resetCheck();
        rst = 1'b0;
        @(negedge clk);

        runMeasurement(allGood, 16'hBEEF, 16'h6666, 1'b1, 1'b0);
        ks = '{K_WNACK, K_WNACK, K_WNACK, K_WNACK};
        runMeasurement(ks, 16'h1234, 16'h5678, 1'b1, 1'b0);
        runMeasurement(allGood, 16'h0102, 16'h0304, 1'b1, 1'b0);
        ks = '{K_BADCRC, K_GOOD, K_GOOD, K_GOOD};
        runMeasurement(ks, 16'hBEEF, 16'h6666, 1'b1, 1'b0);
        ks = '{K_SHORT, K_SHORT, K_SHORT, K_SHORT};
        runMeasurement(ks, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        ks = '{K_EXTRA, K_GOOD, K_GOOD, K_GOOD};
        runMeasurement(ks, 16'hC3A5, 16'h7E81, 1'b1, 1'b0);
        ks = '{K_RNACK, K_BADCRC, K_SHORT, K_RNACK};
        runMeasurement(ks, 16'h4242, 16'h2424, 1'b1, 1'b0);

        for (int m = 0; m < 12; m++) begin
            for (int i = 0; i < 4; i++) ks[i] = randKind();
            runMeasurement(ks, 16'($urandom), 16'($urandom), 1'b1, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] auto-trigger phase");
        auto_en = 1'b1;
        s0 = wr_rise.size();
        for (int m = 0; m < 3; m++) begin
            if (m == 2) begin
                target = wr_rise[$] + PERIOD_CYCLES - 1;
                while (cyc < target) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            runMeasurement(allGood, 16'($urandom), 16'($urandom), 1'b0, m == 1);
        end
        auto_en = 1'b0;
        checkOutput("auto_count", wr_rise.size() - s0, 3);
        if (wr_rise.size() >= s0 + 3) begin
            checkOutput("auto_spacing1", wr_rise[s0 + 1] - wr_rise[s0], PERIOD_CYCLES);
            checkOutput("auto_spacing2", wr_rise[s0 + 2] - wr_rise[s0 + 1], PERIOD_CYCLES);
        end

        $display("[TB] reset during conversion wait");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitReq(1'b0, 50, "wr_req_seen", ok);
        holdAndAck(1'b0);
        pulseDone(1'b0, dc);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        resetCheck();
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset during read request");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitReq(1'b0, 50, "wr_req_seen", ok);
        holdAndAck(1'b0);
        pulseDone(1'b0, dc);
        waitReq(1'b1, WAIT_CYCLES + 50, "rd_req_seen", ok);
        rst = 1'b1;
        @(negedge clk);
        resetCheck();
        rst = 1'b0;
        @(negedge clk);
        runMeasurement(allGood, 16'h6A3C, 16'h91D2, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sht40_measure_sequencer.md
Name: sht40_measure_sequencer

Overview:
Top-level measurement controller for the SHT40 humidity/temperature sensor.
- Sequences the I2C master through each measurement: command write, conversion wait, 6-byte read, CRC-8 check of both words.
- Retries failed measurements and publishes validated raw temperature and RH words.
- Sits between the I2C byte master and downstream conversion/display logic.
- Owns all measurement scheduling: single-shot on request, or periodic auto-trigger.

Parameters:
- I2C_ADDR, 7'h44, sensor 7-bit address.
- MEAS_CMD, 8'hFD, measurement command byte (high precision).
- WAIT_CYCLES, 1000000, clk cycles between write done and read request (≥ 10 ms at 100 MHz).
- PERIOD_CYCLES, 100000000, auto-trigger interval measured start-to-start.
- RETRY_GAP, 1000, clk cycles idle before a retry.
- MAX_RETRY, 3, retries after the first attempt before declaring failure.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle measurement request
- auto_en  in  1  enable periodic triggering
- i2c_req  out  1  transaction request to master
- i2c_rw  out  1  0 = write, 1 = read
- i2c_addr  out  7  target address (= I2C_ADDR)
- i2c_wdata  out  8  write byte (= MEAS_CMD)
- i2c_nbytes  out  3  read length (6 for reads, 0 for writes)
- i2c_ack  in  1  master accepted request
- i2c_rx_valid  in  1  one-cycle strobe with received byte
- i2c_rx_data  in  8  received byte
- i2c_done  in  1  one-cycle transaction-complete strobe
- i2c_nack  in  1  valid with i2c_done; slave NACKed
- temp_raw  out  16  last validated temperature word
- rh_raw  out  16  last validated RH word
- result_valid  out  1  one-cycle pulse when temp_raw/rh_raw update
- busy  out  1  high in every state except IDLE
- error  out  1  one-cycle pulse on final failure
- error_code  out  2  cause of last failure; held until the next failure: 1 NACK, 2 CRC, 3 short read

Behaviour:
- Reset values: all outputs 0 except i2c_addr = I2C_ADDR and i2c_wdata = MEAS_CMD. State IDLE, counters 0.
- Reset mid-transaction: i2c_req drops at the next edge. No handshake completion is required; the master is reset by the same rst.
- States:
  - IDLE: on start, or on auto_en with period counter expired → WR_REQ; attempt count cleared.
  - WR_REQ: i2c_req = 1, rw = 0; hold until i2c_ack is sampled high → WR_WAIT.
  - WR_WAIT: on i2c_done, NACK → FAIL_CHK (code 1); otherwise → MEAS_WAIT.
  - MEAS_WAIT: count WAIT_CYCLES → RD_REQ.
  - RD_REQ: i2c_req = 1, rw = 1, nbytes = 6; hold until i2c_ack → RD_WAIT.
  - RD_WAIT: capture bytes by index 0..5 on i2c_rx_valid; bytes beyond index 5 are ignored. On i2c_done → CHECK.
  - CHECK (1 cycle): evaluate failures in priority order nack (1), byte count < 6 (3), any CRC mismatch (2). Any failure → FAIL_CHK. On pass, update temp_raw = {b0,b1} and rh_raw = {b3,b4} and pulse result_valid in this same cycle's registered outputs → IDLE.
  - FAIL_CHK: if attempts < MAX_RETRY, increment and wait RETRY_GAP → WR_REQ. Otherwise pulse error, latch error_code → IDLE.
- Request fields are stable whenever i2c_req = 1. i2c_req is low in the cycle after ack is sampled.
- CRC: poly 0x31, init 0xFF, MSB first, no final XOR.
  - Computed per byte in a single cycle (unrolled) as bytes arrive.
  - Running CRC reset at b0 and at b3.
  - Compared against b2 and b5 respectively.
- On failure, temp_raw/rh_raw keep their previous values.
- result_valid timing: asserted exactly 2 cycles after the read's i2c_done strobe.
- start while busy: ignored, not queued.
- start and auto-expiry in the same IDLE cycle: one measurement only.
- Period counter:
  - Free-runs while auto_en = 1 and reloads to PERIOD_CYCLES-1 whenever a measurement starts.
  - Saturates at 0 while busy.
  - Held at reload value when auto_en = 0.
- i2c_done arriving in a non-wait state: ignored.

Test Plan:
- start; write ack; read returns BE EF 92 66 66 93 → temp_raw = 16'hBEEF, rh_raw = 16'h6666, one result_valid pulse 2 cycles after read done, error never set.
- Write transaction done with i2c_nack = 1 on every attempt (MAX_RETRY = 3) → exactly 4 write requests with ≥ RETRY_GAP idle between them, then error pulse, error_code = 1, outputs unchanged.
- Read BE EF 93 66 66 93 first, then a correct frame on retry → one retry, result_valid with 16'hBEEF/16'h6666, no error pulse.
- Read done after only 4 bytes on all attempts → error_code = 3 after 4 attempts; bytes after a 6th ignored when 7 are strobed.
- auto_en = 1, PERIOD_CYCLES = 5000, WAIT_CYCLES = 100 → write requests spaced exactly 5000 cycles apart; a start pulse mid-measurement causes no extra request.
- rst asserted during MEAS_WAIT and during RD_REQ → next cycle i2c_req = 0, busy = 0, outputs at reset values; a fresh start completes normally.
